// File: rtl/alu_pkg.sv
// Shared definitions for the decode stage and the ALU: operation codes,
// RV32I opcodes, immediate formats and the EX-stage control bundle.
package alu_pkg;

    localparam int ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_fmt_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic branch_on_zero;
        logic illegal;
    } ex_ctrl_t;

    // funct3 -> operation for the "plain" (funct7 == 0) R-type / I-ALU forms.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  imm_fmt_e              fmt,
    output logic [DATA_WIDTH-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = DATA_WIDTH'($signed(instr[31:20]));
            IMM_S:   imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:   imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX stage: decodes RV32I into ALU code, operands and control bits,
// registered once with flush > stall > load priority under synchronous reset.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iValid,
    input  logic [DATA_WIDTH-1:0]     iInstr,
    input  logic [DATA_WIDTH-1:0]     iPC,
    input  logic [DATA_WIDTH-1:0]     iRs1Data,
    input  logic [DATA_WIDTH-1:0]     iRs2Data,
    input  logic                      iStall,
    input  logic                      iFlush,
    output logic                      oValid,
    output logic [OP_WIDTH-1:0]       oALUControl,
    output logic [DATA_WIDTH-1:0]     oSrcA,
    output logic [DATA_WIDTH-1:0]     oSrcB,
    output logic [DATA_WIDTH-1:0]     oRs2Data,
    output logic [REG_ADDR_WIDTH-1:0] oRdAddr,
    output logic                      oRegWrite,
    output logic                      oMemRead,
    output logic                      oMemWrite,
    output logic                      oBranch,
    output logic                      oBranchOnZero,
    output logic                      oIllegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [REG_ADDR_WIDTH-1:0] rd_field;

    assign opcode   = iInstr[6:0];
    assign funct3   = iInstr[14:12];
    assign funct7   = iInstr[31:25];
    assign rd_field = iInstr[11:7];

    imm_fmt_e              imm_fmt;
    logic [DATA_WIDTH-1:0] imm;

    // Format selection kept apart from decode so the immediate path has no loop.
    always_comb begin
        imm_fmt = IMM_I;
        case (opcode)
            OPC_STORE:          imm_fmt = IMM_S;
            OPC_BRANCH:         imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
            default:            imm_fmt = IMM_I;
        endcase
    end

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr (iInstr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    ex_ctrl_t              dec_ctrl;
    alu_op_e               dec_op;
    logic [DATA_WIDTH-1:0] dec_src_a;
    logic [DATA_WIDTH-1:0] dec_src_b;
    logic                  dec_bad;

    always_comb begin
        dec_ctrl  = '0;
        dec_op    = ALU_ADD;
        dec_src_a = iRs1Data;
        dec_src_b = iRs2Data;
        dec_bad   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_op = base_alu_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_op             = base_alu_op(funct3);
                dec_src_b          = imm;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_src_b = DATA_WIDTH'(iInstr[24:20]);
                    if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                        dec_op = ALU_SRA;
                    end else if (funct7 != 7'b0000000) begin
                        dec_bad = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_src_b          = imm;
            end
            OPC_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_src_b          = imm;
            end
            OPC_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                // "Taken" conditions map onto zero/non-zero of SUB or SLT(U).
                case (funct3)
                    3'b000: begin dec_op = ALU_SUB;  dec_ctrl.branch_on_zero = 1'b1; end
                    3'b001: begin dec_op = ALU_SUB;  dec_ctrl.branch_on_zero = 1'b0; end
                    3'b100: begin dec_op = ALU_SLT;  dec_ctrl.branch_on_zero = 1'b0; end
                    3'b101: begin dec_op = ALU_SLT;  dec_ctrl.branch_on_zero = 1'b1; end
                    3'b110: begin dec_op = ALU_SLTU; dec_ctrl.branch_on_zero = 1'b0; end
                    3'b111: begin dec_op = ALU_SLTU; dec_ctrl.branch_on_zero = 1'b1; end
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_src_a          = '0;
                dec_src_b          = imm;
            end
            OPC_AUIPC: begin
                dec_ctrl.reg_write = 1'b1;
                dec_src_a          = iPC;
                dec_src_b          = imm;
            end
            default: dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
            dec_op           = ALU_ADD;
        end
        if (rd_field == '0) begin
            dec_ctrl.reg_write = 1'b0;
        end
    end

    logic                      valid_q, valid_d;
    ex_ctrl_t                  ctrl_q, ctrl_d;
    alu_op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0]     src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]     src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0]     rs2_q, rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

    // Flush only kills valid/control; datapath holds its (already defined) value.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        if (iFlush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!iStall) begin
            valid_d = iValid;
            ctrl_d  = iValid ? dec_ctrl : '0;
            op_d    = dec_op;
            src_a_d = dec_src_a;
            src_b_d = dec_src_b;
            rs2_d   = iRs2Data;
            rd_d    = rd_field;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            op_q    <= ALU_ADD;
            src_a_q <= '0;
            src_b_q <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    assign oValid        = valid_q;
    assign oALUControl   = op_q;
    assign oSrcA         = src_a_q;
    assign oSrcB         = src_b_q;
    assign oRs2Data      = rs2_q;
    assign oRdAddr       = rd_q;
    assign oRegWrite     = ctrl_q.reg_write;
    assign oMemRead      = ctrl_q.mem_read;
    assign oMemWrite     = ctrl_q.mem_write;
    assign oBranch       = ctrl_q.branch;
    assign oBranchOnZero = ctrl_q.branch_on_zero;
    assign oIllegal      = ctrl_q.illegal;

endmodule
